// File: rtl/accum_pkg.sv
// Shared types and constants for the accumulator controller.
//   DATA_W  : datapath width of samples, operands and the running total
//   state_t : controller states
//               IDLE  - waiting for a sample
//               LOAD  - operands have been registered to the adder
//               WAIT  - operands are held steady while the ripple adder settles
//               STORE - the adder result is captured
//               DONE  - all samples accumulated; results are held
package accum_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        STORE,
        DONE
    } state_t;

endpackage

// File: rtl/accum_16bit_ctrl_if.sv
// Bus between the accumulator controller and the external 16-bit adder.
//   add_a, add_b  : operands (controller -> adder)
//   add_cin       : carry-in (controller -> adder)
//   add_sum       : sum (adder -> controller)
//   add_overflow  : carry-out (adder -> controller)
// Modports:
//   master : the controller side
//   slave  : the adder side
interface accum_16bit_ctrl_if;
    import accum_pkg::*;

    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_b;
    logic              add_cin;
    logic [DATA_W-1:0] add_sum;
    logic              add_overflow;

    modport master (
        output add_a,
        output add_b,
        output add_cin,
        input  add_sum,
        input  add_overflow
    );

    modport slave (
        input  add_a,
        input  add_b,
        input  add_cin,
        output add_sum,
        output add_overflow
    );

endinterface

// File: rtl/adder_16bit.sv
// Purely combinational 16-bit ripple-carry adder, the external partner of
// the accumulator controller.
// Ports:
//   add_bus (slave modport) - sum = add_a + add_b + add_cin,
//                             add_overflow = carry-out of the top bit
module adder_16bit
    import accum_pkg::*;
(
    accum_16bit_ctrl_if.slave add_bus
);

    logic [DATA_W:0]   carry;
    logic [DATA_W-1:0] sum;

    assign carry[0] = add_bus.add_cin;

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
        assign sum[gi]      = add_bus.add_a[gi] ^ add_bus.add_b[gi] ^ carry[gi];
        assign carry[gi+1]  = (add_bus.add_a[gi] & add_bus.add_b[gi])
                            | (carry[gi] & (add_bus.add_a[gi] ^ add_bus.add_b[gi]));
    end

    assign add_bus.add_sum      = sum;
    assign add_bus.add_overflow = carry[DATA_W];

endmodule

// File: rtl/flex_counter.sv
// Parameterised up-counter.
// Ports:
//   clk           : clock, rising edge
//   n_rst         : asynchronous active-low reset, count -> 0
//   clear         : synchronous clear, count -> 0 (wins over count_enable)
//   count_enable  : advance by one this cycle
//   rollover_val  : highest count; advancing from it wraps to 1
//   count         : current count
//   rollover_flag : high while count == rollover_val
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (count_enable) begin
            if (count_reg == rollover_val) begin
                count_reg <= WIDTH'(1);
            end else begin
                count_reg <= count_reg + WIDTH'(1);
            end
        end
    end

    assign count         = count_reg;
    assign rollover_flag = (count_reg == rollover_val);

endmodule

// File: rtl/accum_16bit_ctrl.sv
// Sequential accumulator controller driving an external 16-bit adder.
// Each accepted sample is added to the running total (total -> add_a,
// sample -> add_b); after SETTLE_CYCLES of stable operands the adder result
// is captured. After NUM_SAMPLES captures the block parks in DONE until clear.
// Build option:
//   ACCUM_SATURATE_EN - when defined, a capture that overflows pins the total
//                       at 16'hFFFF instead of wrapping.
// Ports:
//   clk, n_rst        : clock (rising edge), asynchronous active-low reset
//   clear             : synchronous clear of total, count, flags and operands
//   data_valid/data_in: one-cycle sample strobe and unsigned sample value
//   add_bus (master)  : operands/carry-in out, sum/carry-out back
//   accum             : running total
//   sample_count      : samples accumulated so far
//   overflow_flag     : sticky, set by any overflowing capture
//   busy / done       : in LOAD/WAIT/STORE / in DONE
//   overrun           : one-cycle pulse when a sample was dropped
module accum_16bit_ctrl
    import accum_pkg::*;
#(
    parameter int NUM_SAMPLES   = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               clear,
    input  logic                               data_valid,
    input  logic [DATA_W-1:0]                  data_in,
    accum_16bit_ctrl_if.master                 add_bus,
    output logic [DATA_W-1:0]                  accum,
    output logic [$clog2(NUM_SAMPLES+1)-1:0]   sample_count,
    output logic                               overflow_flag,
    output logic                               busy,
    output logic                               done,
    output logic                               overrun
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int COUNT_W  = $clog2(NUM_SAMPLES + 1);

    state_t state_reg, state_next;

    logic [DATA_W-1:0]   accum_reg;
    logic [DATA_W-1:0]   add_a_reg;
    logic [DATA_W-1:0]   add_b_reg;
    logic                overflow_reg;
    logic                overrun_reg;
    logic [SETTLE_W-1:0] settle_count;
    logic                settle_done;
    logic [COUNT_W-1:0]  count_value;
    logic                count_full;
    logic                last_sample;

    // The settle timer starts counting on the LOAD cycle, so it reaches
    // SETTLE_CYCLES after exactly SETTLE_CYCLES cycles spent in WAIT.
    // It is held at zero whenever the controller is idle.
    flex_counter #(.WIDTH(SETTLE_W)) u_settle (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear || (state_reg == IDLE)),
        .count_enable  ((state_reg == LOAD) || ((state_reg == WAIT) && !settle_done)),
        .rollover_val  (SETTLE_W'(SETTLE_CYCLES)),
        .count         (settle_count),
        .rollover_flag (settle_done)
    );

    // The full flag gates the enable so the count can never pass NUM_SAMPLES.
    flex_counter #(.WIDTH(COUNT_W)) u_samples (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear),
        .count_enable  ((state_reg == STORE) && !count_full),
        .rollover_val  (COUNT_W'(NUM_SAMPLES)),
        .count         (count_value),
        .rollover_flag (count_full)
    );

    assign last_sample = (count_value == COUNT_W'(NUM_SAMPLES - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (data_valid) state_next = LOAD;
                LOAD:    state_next = WAIT;
                WAIT:    if (settle_done) state_next = STORE;
                STORE:   state_next = last_sample ? DONE : IDLE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            accum_reg    <= '0;
            add_a_reg    <= '0;
            add_b_reg    <= '0;
            overflow_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else if (clear) begin
            // A sample arriving together with clear is discarded silently.
            accum_reg    <= '0;
            add_a_reg    <= '0;
            add_b_reg    <= '0;
            overflow_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            overrun_reg <= data_valid && (state_reg != IDLE);

            // Operands are latched on the IDLE->LOAD edge and then left alone
            // until the next accepted sample.
            if ((state_reg == IDLE) && data_valid) begin
                add_a_reg <= accum_reg;
                add_b_reg <= data_in;
            end

            if (state_reg == STORE) begin
                overflow_reg <= overflow_reg | add_bus.add_overflow;
`ifdef ACCUM_SATURATE_EN
                accum_reg <= add_bus.add_overflow ? {DATA_W{1'b1}} : add_bus.add_sum;
`else
                accum_reg <= add_bus.add_sum;
`endif
            end
        end
    end

    assign add_bus.add_a   = add_a_reg;
    assign add_bus.add_b   = add_b_reg;
    assign add_bus.add_cin = 1'b0;

    assign accum         = accum_reg;
    assign sample_count  = count_value;
    assign overflow_flag = overflow_reg;
    assign overrun       = overrun_reg;
    assign busy          = (state_reg == LOAD) || (state_reg == WAIT) || (state_reg == STORE);
    assign done          = (state_reg == DONE);

endmodule

// File: tb/tb_accum_16bit_ctrl.sv
// Directed bench for accum_16bit_ctrl paired with adder_16bit.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_accum_16bit_ctrl;

    logic        clk;
    logic        n_rst;
    logic        clear;
    logic        data_valid;
    logic [15:0] data_in;
    logic [15:0] accum;
    logic [2:0]  sample_count;
    logic        overflow_flag;
    logic        busy;
    logic        done;
    logic        overrun;

    int checks;
    int failures;

    accum_16bit_ctrl_if add_bus ();

    adder_16bit u_adder (
        .add_bus (add_bus)
    );

    accum_16bit_ctrl #(
        .NUM_SAMPLES   (4),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear),
        .data_valid    (data_valid),
        .data_in       (data_in),
        .add_bus       (add_bus),
        .accum         (accum),
        .sample_count  (sample_count),
        .overflow_flag (overflow_flag),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle sample strobe; returns 1 unit after the accepting edge.
    task automatic pulse(input logic [15:0] v);
        data_in    = v;
        data_valid = 1'b1;
        cyc(1);
        data_valid = 1'b0;
    endtask

    // Sample followed by idle time: 6 cycles between strobes.
    task automatic feed(input logic [15:0] v);
        pulse(v);
        cyc(5);
    endtask

    task automatic do_clear;
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        cyc(2);
        checks++;
        if ({accum, sample_count, overflow_flag, busy, done, overrun} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs got accum=%h cnt=%0d ovf=%b busy=%b done=%b overrun=%b exp all 0",
                     accum, sample_count, overflow_flag, busy, done, overrun);
        end
        checks++;
        if ({add_bus.add_a, add_bus.add_b, add_bus.add_cin} !== 33'd0) begin
            failures++;
            $display("FAIL reset_operands got a=%h b=%h cin=%b exp 0", add_bus.add_a, add_bus.add_b, add_bus.add_cin);
        end
        #2 n_rst = 1'b1;
        cyc(1);
        $display("test_reset done");
    endtask

    task automatic test_accumulate;
        pulse(16'd1);
        checks++;
        if (busy !== 1'b1 || add_bus.add_a !== 16'd0 || add_bus.add_b !== 16'd1) begin
            failures++;
            $display("FAIL t1_load got busy=%b a=%h b=%h exp busy=1 a=0000 b=0001", busy, add_bus.add_a, add_bus.add_b);
        end
        cyc(2);
        checks++;
        if (add_bus.add_b !== 16'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL t1_wait_hold got b=%h busy=%b exp b=0001 busy=1", add_bus.add_b, busy);
        end
        cyc(1);
        checks++;
        if (accum !== 16'd0) begin
            failures++;
            $display("FAIL t1_latency_early got accum=%h exp 0000", accum);
        end
        cyc(1);
        checks++;
        if (accum !== 16'd1 || sample_count !== 3'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL t1_first_store got accum=%h cnt=%0d busy=%b exp accum=0001 cnt=1 busy=0", accum, sample_count, busy);
        end
        cyc(1);
        feed(16'd2);
        feed(16'd3);
        feed(16'd4);
        checks++;
        if (accum !== 16'd10 || sample_count !== 3'd4 || done !== 1'b1 || overflow_flag !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL t1_final got accum=%0d cnt=%0d done=%b ovf=%b busy=%b exp accum=10 cnt=4 done=1 ovf=0 busy=0",
                     accum, sample_count, done, overflow_flag, busy);
        end
        $display("test_accumulate done");
    endtask

    task automatic test_overflow;
        logic [15:0] exp_acc;
`ifdef ACCUM_SATURATE_EN
        exp_acc = 16'hFFFF;
`else
        exp_acc = 16'h0001;
`endif
        do_clear();
        checks++;
        if (done !== 1'b0 || sample_count !== 3'd0 || accum !== 16'd0) begin
            failures++;
            $display("FAIL t2_clear got done=%b cnt=%0d accum=%h exp 0 0 0000", done, sample_count, accum);
        end
        feed(16'hFFFF);
        feed(16'h0002);
        checks++;
        if (accum !== exp_acc || overflow_flag !== 1'b1 || sample_count !== 3'd2) begin
            failures++;
            $display("FAIL t2_overflow got accum=%h ovf=%b cnt=%0d exp accum=%h ovf=1 cnt=2",
                     accum, overflow_flag, sample_count, exp_acc);
        end
        $display("test_overflow done");
    endtask

    task automatic test_overrun;
        do_clear();
        pulse(16'd5);
        data_in    = 16'd9;
        data_valid = 1'b1;
        cyc(1);
        data_valid = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL t3_overrun_pulse got overrun=%b exp 1", overrun);
        end
        cyc(1);
        checks++;
        if (overrun !== 1'b0 || add_bus.add_b !== 16'd5) begin
            failures++;
            $display("FAIL t3_overrun_once got overrun=%b b=%h exp overrun=0 b=0005", overrun, add_bus.add_b);
        end
        cyc(2);
        checks++;
        if (accum !== 16'd5 || sample_count !== 3'd1) begin
            failures++;
            $display("FAIL t3_result got accum=%h cnt=%0d exp accum=0005 cnt=1", accum, sample_count);
        end
        cyc(1);
        $display("test_overrun done");
    endtask

    task automatic test_clear_mid_add;
        do_clear();
        feed(16'd2);
        pulse(16'h1234);
        cyc(1);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        checks++;
        if (busy !== 1'b0 || accum !== 16'd0 || add_bus.add_a !== 16'd0 || add_bus.add_b !== 16'd0 || sample_count !== 3'd0) begin
            failures++;
            $display("FAIL t4_clear got busy=%b accum=%h a=%h b=%h cnt=%0d exp all 0",
                     busy, accum, add_bus.add_a, add_bus.add_b, sample_count);
        end
        cyc(3);
        checks++;
        if (accum !== 16'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL t4_no_stray_store got accum=%h busy=%b exp 0000 0", accum, busy);
        end
        feed(16'd7);
        checks++;
        if (accum !== 16'd7 || sample_count !== 3'd1) begin
            failures++;
            $display("FAIL t4_after_clear got accum=%h cnt=%0d exp 0007 1", accum, sample_count);
        end
        $display("test_clear_mid_add done");
    endtask

    task automatic test_done_hold;
        do_clear();
        feed(16'd1);
        feed(16'd1);
        feed(16'd1);
        feed(16'd1);
        pulse(16'd9);
        checks++;
        if (overrun !== 1'b1 || accum !== 16'd4 || done !== 1'b1) begin
            failures++;
            $display("FAIL t5_done_overrun got overrun=%b accum=%h done=%b exp 1 0004 1", overrun, accum, done);
        end
        cyc(3);
        checks++;
        if (overrun !== 1'b0 || accum !== 16'd4 || sample_count !== 3'd4 || done !== 1'b1) begin
            failures++;
            $display("FAIL t5_done_hold got overrun=%b accum=%h cnt=%0d done=%b exp 0 0004 4 1",
                     overrun, accum, sample_count, done);
        end
        do_clear();
        checks++;
        if (done !== 1'b0 || sample_count !== 3'd0 || accum !== 16'd0) begin
            failures++;
            $display("FAIL t5_clear got done=%b cnt=%0d accum=%h exp 0 0 0000", done, sample_count, accum);
        end
        $display("test_done_hold done");
    endtask

    task automatic test_async_reset;
        do_clear();
        feed(16'd6);
        pulse(16'd3);
        cyc(3);
        checks++;
        if (busy !== 1'b1 || add_bus.add_a !== 16'd6 || add_bus.add_b !== 16'd3) begin
            failures++;
            $display("FAIL t6_pre got busy=%b a=%h b=%h exp 1 0006 0003", busy, add_bus.add_a, add_bus.add_b);
        end
        #1 n_rst = 1'b0;
        #1;
        checks++;
        if ({accum, sample_count, overflow_flag, busy, done, overrun} !== 22'd0 ||
            add_bus.add_a !== 16'd0 || add_bus.add_b !== 16'd0) begin
            failures++;
            $display("FAIL t6_async got accum=%h cnt=%0d busy=%b a=%h b=%h exp all 0",
                     accum, sample_count, busy, add_bus.add_a, add_bus.add_b);
        end
        #3 n_rst = 1'b1;
        cyc(2);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || accum !== 16'd0) begin
            failures++;
            $display("FAIL t6_idle got busy=%b done=%b accum=%h exp 0 0 0000", busy, done, accum);
        end
        feed(16'd8);
        checks++;
        if (accum !== 16'd8 || sample_count !== 3'd1) begin
            failures++;
            $display("FAIL t6_resume got accum=%h cnt=%0d exp 0008 1", accum, sample_count);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        n_rst      = 1'b0;
        clear      = 1'b0;
        data_valid = 1'b0;
        data_in    = 16'd0;
        test_reset();
        test_accumulate();
        test_overflow();
        test_overrun();
        test_clear_mid_add();
        test_done_hold();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
